// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions: response codes and the per-path FSM state types
// used by the UART command bridge.
package axil_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam int unsigned AXIL_ADDR_W = 32;
    localparam int unsigned AXIL_DATA_W = 32;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_REQ  = 2'd1,
        W_RESP = 2'd2
    } axil_wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_REQ  = 2'd1,
        R_RESP = 2'd2
    } axil_rd_state_t;

endpackage

// File: rtl/axil_master_bridge.sv
// Turns single-beat write/read commands from the UART frame parser into AXI4-Lite
// master transactions; write and read paths run independently and concurrently.
module axil_master_bridge
    import axil_pkg::*;
#(
    parameter logic [2:0] AXI_PROT  = 3'b000,
    parameter logic [3:0] AXI_WSTRB = 4'b1111
) (
    input  logic        aclk,
    input  logic        aresetn,

    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data,
    output logic        wr_done,
    output logic [1:0]  wr_error,

    input  logic        rd_valid,
    output logic        rd_ready,
    input  logic [31:0] rd_addr,
    output logic [31:0] rd_data,
    output logic        rd_done,
    output logic [1:0]  rd_error,

    output logic        m_axil_awvalid,
    input  logic        m_axil_awready,
    output logic [31:0] m_axil_awaddr,
    output logic [2:0]  m_axil_awprot,

    output logic        m_axil_wvalid,
    input  logic        m_axil_wready,
    output logic [31:0] m_axil_wdata,
    output logic [3:0]  m_axil_wstrb,

    input  logic        m_axil_bvalid,
    output logic        m_axil_bready,
    input  logic [1:0]  m_axil_bresp,

    output logic        m_axil_arvalid,
    input  logic        m_axil_arready,
    output logic [31:0] m_axil_araddr,
    output logic [2:0]  m_axil_arprot,

    input  logic        m_axil_rvalid,
    output logic        m_axil_rready,
    input  logic [31:0] m_axil_rdata,
    input  logic [1:0]  m_axil_rresp
);

    axil_wr_state_t wr_state_q;
    logic        wr_ready_q;
    logic        wr_done_q;
    logic [1:0]  wr_error_q;
    logic        awvalid_q;
    logic        wvalid_q;
    logic        bready_q;
    logic [31:0] awaddr_q;
    logic [31:0] wdata_q;
    logic        aw_done_q;
    logic        w_done_q;

    axil_rd_state_t rd_state_q;
    logic        rd_ready_q;
    logic        rd_done_q;
    logic [1:0]  rd_error_q;
    logic [31:0] rd_data_q;
    logic        arvalid_q;
    logic        rready_q;
    logic [31:0] araddr_q;

    logic        aw_hs_s;
    logic        w_hs_s;
    logic        b_hs_s;
    logic        ar_hs_s;
    logic        r_hs_s;
    logic        aw_done_d;
    logic        w_done_d;

    // Channel handshakes and the running AW/W completion flags for this cycle.
    always_comb begin
        aw_hs_s   = 1'b0;
        w_hs_s    = 1'b0;
        b_hs_s    = 1'b0;
        ar_hs_s   = 1'b0;
        r_hs_s    = 1'b0;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        aw_hs_s   = awvalid_q & m_axil_awready;
        w_hs_s    = wvalid_q & m_axil_wready;
        b_hs_s    = bready_q & m_axil_bvalid;
        ar_hs_s   = arvalid_q & m_axil_arready;
        r_hs_s    = rready_q & m_axil_rvalid;
        aw_done_d = aw_done_q | aw_hs_s;
        w_done_d  = w_done_q | w_hs_s;
    end

    // Write path FSM: accept a command, drive AW and W independently, collect B.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_state_q <= W_IDLE;
            wr_ready_q <= 1'b0;
            wr_done_q  <= 1'b0;
            wr_error_q <= AXI_RESP_OKAY;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            bready_q   <= 1'b0;
            awaddr_q   <= 32'h0000_0000;
            wdata_q    <= 32'h0000_0000;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
        end else begin
            wr_done_q <= 1'b0;
            case (wr_state_q)
                W_IDLE: begin
                    if (wr_ready_q && wr_valid) begin
                        awaddr_q   <= wr_addr;
                        wdata_q    <= wr_data;
                        wr_ready_q <= 1'b0;
                        awvalid_q  <= 1'b1;
                        wvalid_q   <= 1'b1;
                        aw_done_q  <= 1'b0;
                        w_done_q   <= 1'b0;
                        wr_state_q <= W_REQ;
                    end else begin
                        wr_ready_q <= 1'b1;
                    end
                end
                W_REQ: begin
                    if (aw_hs_s) begin
                        awvalid_q <= 1'b0;
                    end
                    if (w_hs_s) begin
                        wvalid_q <= 1'b0;
                    end
                    // Both channels may finish in the same cycle; look at the merged flags.
                    if (aw_done_d && w_done_d) begin
                        bready_q   <= 1'b1;
                        aw_done_q  <= 1'b0;
                        w_done_q   <= 1'b0;
                        wr_state_q <= W_RESP;
                    end else begin
                        aw_done_q <= aw_done_d;
                        w_done_q  <= w_done_d;
                    end
                end
                W_RESP: begin
                    if (b_hs_s) begin
                        bready_q   <= 1'b0;
                        wr_error_q <= m_axil_bresp;
                        wr_done_q  <= 1'b1;
                        wr_state_q <= W_IDLE;
                    end else begin
                        bready_q <= 1'b1;
                    end
                end
                default: begin
                    wr_state_q <= W_IDLE;
                    wr_ready_q <= 1'b0;
                    awvalid_q  <= 1'b0;
                    wvalid_q   <= 1'b0;
                    bready_q   <= 1'b0;
                    aw_done_q  <= 1'b0;
                    w_done_q   <= 1'b0;
                end
            endcase
        end
    end

    // Read path FSM: accept a command, drive AR, collect R data and response.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            rd_state_q <= R_IDLE;
            rd_ready_q <= 1'b0;
            rd_done_q  <= 1'b0;
            rd_error_q <= AXI_RESP_OKAY;
            rd_data_q  <= 32'h0000_0000;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            araddr_q   <= 32'h0000_0000;
        end else begin
            rd_done_q <= 1'b0;
            case (rd_state_q)
                R_IDLE: begin
                    if (rd_ready_q && rd_valid) begin
                        araddr_q   <= rd_addr;
                        rd_ready_q <= 1'b0;
                        arvalid_q  <= 1'b1;
                        rd_state_q <= R_REQ;
                    end else begin
                        rd_ready_q <= 1'b1;
                    end
                end
                R_REQ: begin
                    if (ar_hs_s) begin
                        arvalid_q  <= 1'b0;
                        rready_q   <= 1'b1;
                        rd_state_q <= R_RESP;
                    end else begin
                        arvalid_q <= 1'b1;
                    end
                end
                R_RESP: begin
                    if (r_hs_s) begin
                        rready_q   <= 1'b0;
                        rd_data_q  <= m_axil_rdata;
                        rd_error_q <= m_axil_rresp;
                        rd_done_q  <= 1'b1;
                        rd_state_q <= R_IDLE;
                    end else begin
                        rready_q <= 1'b1;
                    end
                end
                default: begin
                    rd_state_q <= R_IDLE;
                    rd_ready_q <= 1'b0;
                    arvalid_q  <= 1'b0;
                    rready_q   <= 1'b0;
                end
            endcase
        end
    end

    assign wr_ready       = wr_ready_q;
    assign wr_done        = wr_done_q;
    assign wr_error       = wr_error_q;
    assign rd_ready       = rd_ready_q;
    assign rd_done        = rd_done_q;
    assign rd_error       = rd_error_q;
    assign rd_data        = rd_data_q;

    assign m_axil_awvalid = awvalid_q;
    assign m_axil_awaddr  = awaddr_q;
    assign m_axil_awprot  = AXI_PROT;
    assign m_axil_wvalid  = wvalid_q;
    assign m_axil_wdata   = wdata_q;
    assign m_axil_wstrb   = AXI_WSTRB;
    assign m_axil_bready  = bready_q;
    assign m_axil_arvalid = arvalid_q;
    assign m_axil_araddr  = araddr_q;
    assign m_axil_arprot  = AXI_PROT;
    assign m_axil_rready  = rready_q;

endmodule

// File: tb/tb_axil_master_bridge.sv
// Bench for axil_master_bridge: a stall-configurable AXI-Lite slave plus a
// transaction-level model that predicts every bridge output on every cycle.
module tb_axil_master_bridge;

    logic        aclk = 1'b0;
    always #5 aclk = ~aclk;

    logic        aresetn;
    logic        wr_valid, wr_ready, wr_done;
    logic [31:0] wr_addr, wr_data;
    logic [1:0]  wr_error;
    logic        rd_valid, rd_ready, rd_done;
    logic [31:0] rd_addr, rd_data;
    logic [1:0]  rd_error;
    logic        m_axil_awvalid, m_axil_awready;
    logic [31:0] m_axil_awaddr;
    logic [2:0]  m_axil_awprot;
    logic        m_axil_wvalid, m_axil_wready;
    logic [31:0] m_axil_wdata;
    logic [3:0]  m_axil_wstrb;
    logic        m_axil_bvalid, m_axil_bready;
    logic [1:0]  m_axil_bresp;
    logic        m_axil_arvalid, m_axil_arready;
    logic [31:0] m_axil_araddr;
    logic [2:0]  m_axil_arprot;
    logic        m_axil_rvalid, m_axil_rready;
    logic [31:0] m_axil_rdata;
    logic [1:0]  m_axil_rresp;

    axil_master_bridge #(.AXI_PROT(3'b010), .AXI_WSTRB(4'b0011)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_done(wr_done), .wr_error(wr_error),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_done(rd_done), .rd_error(rd_error),
        .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
        .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
        .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
        .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
        .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready), .m_axil_bresp(m_axil_bresp),
        .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
        .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot),
        .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready),
        .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // slave configuration
    int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
    logic [31:0] cfg_rdata = 32'h0;

    // transaction-level model state
    bit          started = 1'b0;
    bit          wbusy = 1'b0, rbusy = 1'b0, got_aw = 1'b0, got_w = 1'b0, got_ar = 1'b0;
    logic [31:0] exp_awaddr = 32'h0, exp_wdata = 32'h0, exp_araddr = 32'h0;
    logic [31:0] last_rdata = 32'h0, hs_awaddr = 32'h0, hs_wdata = 32'h0, hs_araddr = 32'h0;
    logic [1:0]  last_bresp = 2'b00, last_rresp = 2'b00;
    bit          rst_p = 1'b0, wacc_p = 1'b0, racc_p = 1'b0;
    bit          aw_hs_p = 1'b0, w_hs_p = 1'b0, b_hs_p = 1'b0, ar_hs_p = 1'b0, r_hs_p = 1'b0;
    logic [31:0] pw_addr = 32'h0, pw_data = 32'h0, pr_addr = 32'h0;
    int          aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
    int          wacc_cnt = 0, racc_cnt = 0, wdone_cnt = 0, rdone_cnt = 0;
    int          wacc_cyc = 0, racc_cyc = 0, wdone_cyc = 0, rdone_cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Apply the effects of the handshakes that fired on the edge just passed,
    // compare every output, then drive the slave for the next edge.
    always @(negedge aclk) begin
        cyc++;
        if (rst_p) begin
            started = 1'b1;
            wbusy = 1'b0; rbusy = 1'b0; got_aw = 1'b0; got_w = 1'b0; got_ar = 1'b0;
            last_bresp = 2'b00; last_rresp = 2'b00; last_rdata = 32'h0;
            m_axil_awready = 1'b0; m_axil_wready = 1'b0; m_axil_bvalid = 1'b0;
            m_axil_arready = 1'b0; m_axil_rvalid = 1'b0;
            aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        end else begin
            if (wacc_p) begin
                wbusy = 1'b1; got_aw = 1'b0; got_w = 1'b0;
                exp_awaddr = pw_addr; exp_wdata = pw_data;
            end
            if (racc_p) begin
                rbusy = 1'b1; got_ar = 1'b0; exp_araddr = pr_addr;
            end
            if (aw_hs_p) begin got_aw = 1'b1; m_axil_awready = 1'b0; aw_cnt = 0; end
            if (w_hs_p)  begin got_w  = 1'b1; m_axil_wready  = 1'b0; w_cnt  = 0; end
            if (ar_hs_p) begin got_ar = 1'b1; m_axil_arready = 1'b0; ar_cnt = 0; end
            if (b_hs_p) begin
                wbusy = 1'b0; got_aw = 1'b0; got_w = 1'b0;
                last_bresp = m_axil_bresp; m_axil_bvalid = 1'b0; b_cnt = 0;
                wdone_cnt++; wdone_cyc = cyc;
            end
            if (r_hs_p) begin
                rbusy = 1'b0; got_ar = 1'b0;
                last_rdata = m_axil_rdata; last_rresp = m_axil_rresp;
                m_axil_rvalid = 1'b0; r_cnt = 0;
                rdone_cnt++; rdone_cyc = cyc;
            end
        end

        if (started) begin
            chk("wr_ready", 32'(wr_ready), 32'(!rst_p && !wbusy && !b_hs_p));
            chk("rd_ready", 32'(rd_ready), 32'(!rst_p && !rbusy && !r_hs_p));
            chk("awvalid", 32'(m_axil_awvalid), 32'(wbusy && !got_aw));
            chk("wvalid", 32'(m_axil_wvalid), 32'(wbusy && !got_w));
            chk("bready", 32'(m_axil_bready), 32'(wbusy && got_aw && got_w));
            chk("arvalid", 32'(m_axil_arvalid), 32'(rbusy && !got_ar));
            chk("rready", 32'(m_axil_rready), 32'(rbusy && got_ar));
            chk("wr_done", 32'(wr_done), 32'(!rst_p && b_hs_p));
            chk("rd_done", 32'(rd_done), 32'(!rst_p && r_hs_p));
            chk("wr_error", 32'(wr_error), 32'(last_bresp));
            chk("rd_error", 32'(rd_error), 32'(last_rresp));
            chk("rd_data", rd_data, last_rdata);
            chk("awprot", 32'(m_axil_awprot), 32'h2);
            chk("arprot", 32'(m_axil_arprot), 32'h2);
            chk("wstrb", 32'(m_axil_wstrb), 32'h3);
            if (m_axil_awvalid) chk("awaddr", m_axil_awaddr, exp_awaddr);
            if (m_axil_wvalid)  chk("wdata", m_axil_wdata, exp_wdata);
            if (m_axil_arvalid) chk("araddr", m_axil_araddr, exp_araddr);
        end

        if (m_axil_awvalid && !m_axil_awready) begin
            if (aw_cnt >= aw_dly) m_axil_awready = 1'b1; else aw_cnt++;
        end
        if (m_axil_wvalid && !m_axil_wready) begin
            if (w_cnt >= w_dly) m_axil_wready = 1'b1; else w_cnt++;
        end
        if (got_aw && got_w && !m_axil_bvalid) begin
            if (b_cnt >= b_dly) begin m_axil_bvalid = 1'b1; m_axil_bresp = cfg_bresp; end
            else b_cnt++;
        end
        if (m_axil_arvalid && !m_axil_arready) begin
            if (ar_cnt >= ar_dly) m_axil_arready = 1'b1; else ar_cnt++;
        end
        if (got_ar && !m_axil_rvalid) begin
            if (r_cnt >= r_dly) begin
                m_axil_rvalid = 1'b1; m_axil_rdata = cfg_rdata; m_axil_rresp = cfg_rresp;
            end else r_cnt++;
        end

        rst_p   = !aresetn;
        wacc_p  = aresetn && wr_valid && wr_ready;
        racc_p  = aresetn && rd_valid && rd_ready;
        aw_hs_p = aresetn && m_axil_awvalid && m_axil_awready;
        w_hs_p  = aresetn && m_axil_wvalid && m_axil_wready;
        b_hs_p  = aresetn && m_axil_bvalid && m_axil_bready;
        ar_hs_p = aresetn && m_axil_arvalid && m_axil_arready;
        r_hs_p  = aresetn && m_axil_rvalid && m_axil_rready;
        if (aw_hs_p) hs_awaddr = m_axil_awaddr;
        if (w_hs_p)  hs_wdata  = m_axil_wdata;
        if (ar_hs_p) hs_araddr = m_axil_araddr;
        if (wacc_p) begin pw_addr = wr_addr; pw_data = wr_data; wacc_cnt++; wacc_cyc = cyc; end
        if (racc_p) begin pr_addr = rd_addr; racc_cnt++; racc_cyc = cyc; end
    end

    task automatic start_req(input bit dw, input bit dr,
                             input logic [31:0] wa, input logic [31:0] wd, input logic [31:0] ra);
        int w0, r0;
        bit wpend, rpend;
        w0 = wacc_cnt; r0 = racc_cnt; wpend = dw; rpend = dr;
        wr_addr = wa; wr_data = wd; rd_addr = ra;
        wr_valid = dw; rd_valid = dr;
        for (int i = 0; i < 100 && (wpend || rpend); i++) begin
            @(posedge aclk); #2;
            if (wpend && wacc_cnt != w0) begin wpend = 1'b0; wr_valid = 1'b0; end
            if (rpend && racc_cnt != r0) begin rpend = 1'b0; rd_valid = 1'b0; end
        end
        chk("accept_timeout", 32'(wpend || rpend), 32'h0);
        wr_valid = 1'b0; rd_valid = 1'b0;
    endtask

    task automatic wait_done(input int tw, input int tr);
        int i;
        i = 0;
        while ((wdone_cnt < tw || rdone_cnt < tr) && i < 400) begin
            @(posedge aclk); #2;
            i++;
        end
        chk("done_timeout", 32'(wdone_cnt >= tw && rdone_cnt >= tr), 32'h1);
    endtask

    initial begin
        int tw, tr;
        aresetn = 1'b0; wr_valid = 1'b0; rd_valid = 1'b0;
        wr_addr = 32'h0; wr_data = 32'h0; rd_addr = 32'h0;
        m_axil_awready = 1'b0; m_axil_wready = 1'b0; m_axil_bvalid = 1'b0; m_axil_bresp = 2'b00;
        m_axil_arready = 1'b0; m_axil_rvalid = 1'b0; m_axil_rdata = 32'h0; m_axil_rresp = 2'b00;
        repeat (3) @(posedge aclk);
        #2;
        chk("reset_wr_ready", 32'(wr_ready), 32'h0);
        chk("reset_rd_data", rd_data, 32'h0);
        aresetn = 1'b1;
        @(posedge aclk); #2;
        chk("ready_after_release", 32'({wr_ready, rd_ready}), 32'h3);

        // basic write, slave always ready, OKAY
        tw = wdone_cnt + 1;
        start_req(1'b1, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0);
        wait_done(tw, rdone_cnt);
        chk("t1_latency", 32'(wdone_cyc - wacc_cyc), 32'd3);
        chk("t1_awaddr", hs_awaddr, 32'h0000_0010);
        chk("t1_wdata", hs_wdata, 32'hDEAD_BEEF);
        chk("t1_wr_error", 32'(wr_error), 32'h0);

        // read returning SLVERR
        cfg_rdata = 32'h1234_5678; cfg_rresp = 2'b10;
        tr = rdone_cnt + 1;
        start_req(1'b0, 1'b1, 32'h0, 32'h0, 32'h0000_0020);
        wait_done(wdone_cnt, tr);
        chk("t2_latency", 32'(rdone_cyc - racc_cyc), 32'd3);
        chk("t2_araddr", hs_araddr, 32'h0000_0020);
        chk("t2_rd_data", rd_data, 32'h1234_5678);
        chk("t2_rd_error", 32'(rd_error), 32'h2);
        chk("t2_rd_done_width", 32'(rd_done), 32'h0);

        // awready held off five cycles, wready immediate
        aw_dly = 5; cfg_bresp = 2'b00;
        tw = wdone_cnt + 1;
        start_req(1'b1, 1'b0, 32'h0000_0100, 32'hA5A5_0F0F, 32'h0);
        wait_done(tw, rdone_cnt);
        chk("t3_latency", 32'(wdone_cyc - wacc_cyc), 32'd8);
        chk("t3_awaddr", hs_awaddr, 32'h0000_0100);

        // concurrent write and read with random slave stalls
        for (int k = 0; k < 4; k++) begin
            aw_dly = $urandom_range(0, 4); w_dly = $urandom_range(0, 4);
            b_dly  = $urandom_range(0, 4); ar_dly = $urandom_range(0, 4);
            r_dly  = $urandom_range(0, 4);
            cfg_bresp = 2'($urandom_range(0, 3)); cfg_rresp = 2'($urandom_range(0, 3));
            cfg_rdata = $urandom;
            tw = wdone_cnt + 1; tr = rdone_cnt + 1;
            start_req(1'b1, 1'b1, 32'h1000 + 32'(k * 4), $urandom, 32'h2000 + 32'(k * 4));
            chk("t4_same_accept", 32'(wacc_cyc), 32'(racc_cyc));
            wait_done(tw, tr);
        end

        // long B stall with a second write queued behind it
        aw_dly = 0; w_dly = 0; b_dly = 20; cfg_bresp = 2'b11;
        tw = wdone_cnt + 2;
        start_req(1'b1, 1'b0, 32'h0000_0300, 32'h1111_1111, 32'h0);
        start_req(1'b1, 1'b0, 32'h0000_0304, 32'h2222_2222, 32'h0);
        chk("t5_accept_gap", 32'(wacc_cyc - wdone_cyc), 32'd1);
        wait_done(tw, rdone_cnt);
        chk("t5_awaddr", hs_awaddr, 32'h0000_0304);
        chk("t5_wr_error", 32'(wr_error), 32'h3);

        // reset in the middle of the address phase
        aw_dly = 10; b_dly = 0; cfg_bresp = 2'b01;
        start_req(1'b1, 1'b0, 32'h0000_0400, 32'h3333_3333, 32'h0);
        @(posedge aclk); #2;
        aresetn = 1'b0;
        @(posedge aclk); #2;
        chk("t6_awvalid", 32'(m_axil_awvalid), 32'h0);
        chk("t6_wr_ready", 32'(wr_ready), 32'h0);
        aresetn = 1'b1;
        @(posedge aclk); #2;
        chk("t6_ready_after", 32'(wr_ready), 32'h1);
        aw_dly = 0;
        tw = wdone_cnt + 1;
        start_req(1'b1, 1'b0, 32'h0000_0500, 32'h4444_4444, 32'h0);
        wait_done(tw, rdone_cnt);
        chk("t6_recover_err", 32'(wr_error), 32'h1);
        chk("t6_recover_lat", 32'(wdone_cyc - wacc_cyc), 32'd3);

        repeat (3) @(posedge aclk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axil_master_bridge.md
# axil_master_bridge

Converts single-beat register commands from the UART frame parser/generator into AXI4-Lite master transactions. It sits directly downstream of the parser/generator, consuming its `wr_*`/`rd_*` request/response handshakes and driving the system AXI-Lite interconnect. Write and read paths are independent and may be in flight simultaneously; the AXI response code is returned unchanged as the 2-bit error.

## Interface
- `AXI_PROT`, default 3'b000: constant value driven on `m_axil_awprot` and `m_axil_arprot`.
- `AXI_WSTRB`, default 4'b1111: constant value driven on `m_axil_wstrb`.
- `aclk` in 1: sole clock.
- `aresetn` in 1: reset; synchronous, active-low (the single clock is `aclk`).
- `wr_valid` in 1: write request; held high until `wr_ready`.
- `wr_ready` out 1: write path idle and accepting.
- `wr_addr`, `wr_data` in 32 each: write address and data, sampled on accept.
- `wr_done` out 1: one-cycle pulse; write complete.
- `wr_error` out 2: BRESP of the completed write; valid with `wr_done` and held afterwards.
- `rd_valid` in 1, `rd_ready` out 1, `rd_addr` in 32: read request handshake, same rules as write.
- `rd_data` out 32: RDATA, valid with `rd_done` and held afterwards.
- `rd_done` out 1: one-cycle pulse; read complete.
- `rd_error` out 2: RRESP.
- `m_axil_aw{valid,ready,addr,prot}`, `m_axil_w{valid,ready,data,strb}`, `m_axil_b{valid,ready,resp}`, `m_axil_ar{valid,ready,addr,prot}`, `m_axil_r{valid,ready,data,resp}`: standard AXI4-Lite master, 32-bit address and data.

## Operation
- Write FSM: `W_IDLE`, `W_REQ`, `W_RESP`.
  - `W_IDLE`: `wr_ready`=1. If `wr_valid`, capture address and data, drive `wr_ready`<=0, `awvalid`<=1, `wvalid`<=1, and go to `W_REQ`.
  - `W_REQ`: AW and W complete independently. Each valid drops on its own handshake; the `aw_done`/`w_done` flags record completion. When both have completed, including completion in the same cycle, set `bready`<=1 and go to `W_RESP`.
  - `W_RESP`: on `bvalid && bready`, set `bready`<=0, `wr_error`<=bresp, pulse `wr_done`, and go to `W_IDLE`.
- Read FSM: `R_IDLE`, `R_REQ`, `R_RESP`.
  - `R_IDLE`: `rd_ready`=1. On `rd_valid`, capture the address, set `arvalid`<=1, and go to `R_REQ`.
  - `R_REQ`: on the AR handshake, set `arvalid`<=0, `rready`<=1, and go to `R_RESP`.
  - `R_RESP`: on the R handshake, register `rd_data` and `rd_error` and pulse `rd_done`.
- Request fields (`awaddr`, `wdata`, `araddr`) are stable while the corresponding valid is high. Valids never drop without a handshake.
- Simultaneous write and read requests: both are accepted in the same cycle, and the AXI channels run concurrently. There is no ordering guarantee between `wr_done` and `rd_done`.
- A `wr_valid` that arrives while the write FSM is busy waits because `wr_ready`=0. Read behaves the same way.
- Responses are not checked: SLVERR (2'b10) and DECERR (2'b11) pass through verbatim. No timeout is applied; a slave that never responds stalls that path only.
- Reset mid-transaction: all FSMs return to IDLE and all valids/readies go low on the next edge. The outstanding transaction is abandoned and the interconnect is reset alongside.

## Timing
- Reset values:
  - `wr_ready`, `rd_ready`, `wr_done`, `rd_done` = 0.
  - All AXI valids and readies = 0.
  - `wr_error`, `rd_error` = 2'b00; `rd_data` = 0.
- `wr_ready`/`rd_ready` rise on the first cycle after `aresetn` is released.
- All outputs are registered.
- Minimum write latency, with the slave always ready:
  - T0: `wr_valid` and `wr_ready` both high.
  - T1: AW and W handshakes complete.
  - T2: `bready` high; handshake completes if `bvalid` is already high.
  - T3: `wr_done` high.
  - T4: `wr_ready` high again.
- Read minimum latency is identical: `rd_done` at T3.
- `wr_done`/`rd_done` are exactly one cycle wide.

## Structure
- Shared `axil_pkg`:
  - resp constants `AXI_RESP_OKAY`=2'b00, `EXOKAY`=2'b01, `SLVERR`=2'b10, `DECERR`=2'b11;
  - enums `axil_wr_state_t` and `axil_rd_state_t`.
- Single module with two independent `always_ff` FSMs. No sub-module is required.

## Test plan
- Write addr 0x0000_0010, data 0xDEADBEEF; slave always ready with OKAY -> AW/W fields match, `wr_done` at T3, `wr_error`=00.
- Read addr 0x0000_0020; slave returns 0x12345678 with SLVERR -> `rd_data`=0x12345678, `rd_error`=10, single-cycle `rd_done`.
- `awready` delayed 5 cycles, `wready` immediate -> `wvalid` drops at T1, `awvalid` is held with a stable address, and `bready` is asserted only after both handshakes.
- Write and read issued in the same cycle with random slave stalls -> both complete, with each `done` paired to the correct response data.
- `bvalid` held off 20 cycles, then a second `wr_valid` is presented -> `wr_ready` stays 0 until the first `wr_done`, and the second write then completes.
- `aresetn` pulsed low during `W_REQ` -> all valids are 0 the next cycle and `wr_ready`=1 one cycle after release.
